// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the UART byte transmitter.
// The arbiter takes the master modport; the surrounding environment takes the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic               tx_start;
    logic [DW-1:0]      tx_data;
    logic               tx_done;
    logic               busy;
    logic [2:0]         owner;
    logic               timeout_err;

    modport master (
        input  req, req_data, tx_done,
        output grant, tx_start, tx_data, busy, owner, timeout_err
    );

    modport slave (
        output req, req_data, tx_done,
        input  grant, tx_start, tx_data, busy, owner, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NREQ requesters,
// with a completion timeout and a post-frame guard gap.
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 2000000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]    NREQ4    = 4'(NREQ);
    localparam logic [2:0]    LAST_IDX = 3'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    state_t          state;
    logic [2:0]      ptr;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;
    logic [2:0]      winner;
    logic [2*NREQ-1:0] rot;
    logic [2:0]      off;
    logic [3:0]      sum;
    logic            frame_end;

    // Rotate the request vector so the pointer sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        rot = {bus.req, bus.req} >> ptr;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ4) sum = sum - NREQ4;
        winner = sum[2:0];
    end

    // tx_done takes precedence over an expiring timeout on the same cycle.
    assign frame_end = (state == WAIT_DONE) && (bus.tx_done || (tcnt == T_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            tcnt            <= '0;
            gcnt            <= '0;
            bus.grant       <= '0;
            bus.tx_start    <= 1'b0;
            bus.tx_data     <= '0;
            bus.busy        <= 1'b0;
            bus.owner       <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.grant       <= '0;
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.tx_data <= bus.req_data[winner*DW +: DW];
                        bus.owner   <= winner;
                        bus.grant   <= NREQ'(1) << winner;
                        ptr         <= (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
                        bus.busy    <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.tx_start <= 1'b1;
                    tcnt         <= '0;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (frame_end) begin
                        bus.timeout_err <= !bus.tx_done;
                        gcnt            <= '0;
                        if (GAP_CYCLES == 0) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == G_LAST) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
